// File: rtl/term_ctrl_if.sv
// Bus between the terminal engine and its neighbours: rx byte strobe in,
// block write/copy requests out towards the text buffer, plus status.
interface term_ctrl_if #(
    parameter int ADDR_W = 11
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              overflow;
    logic [ADDR_W-1:0] cursor;
    logic              wr_start;
    logic [ADDR_W-1:0] wr_begin;
    logic [ADDR_W-1:0] wr_end;
    logic [7:0]        wr_data;
    logic [ADDR_W-1:0] wr_offset;
    logic              wr_complete;
    logic              busy;

    modport master (
        input  rx_data, rx_valid, wr_complete,
        output overflow, cursor, wr_start, wr_begin, wr_end, wr_data, wr_offset, busy
    );
    modport slave (
        output rx_data, rx_valid, wr_complete,
        input  overflow, cursor, wr_start, wr_begin, wr_end, wr_data, wr_offset, busy
    );
endinterface

// File: rtl/term_ctrl.sv
// Terminal control engine: buffers rx bytes, parses control chars and CSI
// sequences, tracks the cursor and issues fill/copy requests to the text buffer.
module term_ctrl #(
    parameter int COLS       = 80,
    parameter int ROWS       = 25,
    parameter int FIFO_DEPTH = 16,
    parameter int TAB_W      = 8,
    localparam int ADDR_W    = $clog2(COLS*ROWS)
) (
    input logic          clk100,
    input logic          rst_n,
    term_ctrl_if.master  bus
);
    localparam int ROW_W     = $clog2(ROWS);
    localparam int COL_W     = $clog2(COLS);
    localparam int PTR_W     = $clog2(FIFO_DEPTH);
    localparam int CELLS     = COLS*ROWS;
    localparam int LAST_BASE = (ROWS-1)*COLS;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_COPY} state_t;
    typedef enum logic [1:0] {P_DEF, P_ESC, P_CSI} pstate_t;

    state_t            r_state, w_state_next;
    pstate_t           r_pstate, w_pstate_next;
    logic [ROW_W-1:0]  r_row, w_row_next;
    logic [COL_W-1:0]  r_col, w_col_next;
    logic [7:0]        r_p0, w_p0_next, r_p1, w_p1_next;
    logic              r_idx, w_idx_next;
    logic              r_scroll_pend, w_pend_next;
    logic [ADDR_W-1:0] r_cursor;
    logic              r_wr_start, r_overflow;
    logic [ADDR_W-1:0] r_wr_begin, r_wr_end, r_wr_offset;
    logic [7:0]        r_wr_data;
    logic              w_issue;
    logic [ADDR_W-1:0] w_op_begin, w_op_end, w_op_offset;
    logic [7:0]        w_op_data;
    int                w_row_i, w_col_i, w_cur_i, w_n_i, w_acc_i;

    logic [7:0]        r_fifo [FIFO_DEPTH];
    logic [PTR_W:0]    r_wr_ptr, r_rd_ptr;
    logic              w_empty, w_full, w_push, w_pop, w_busy;
    logic [7:0]        w_byte;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                     (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign w_push  = bus.rx_valid && (!w_full || w_pop);
    assign w_byte  = r_fifo[r_rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk100) begin
        if (w_push) r_fifo[r_wr_ptr[PTR_W-1:0]] <= bus.rx_data;
    end

    always_ff @(posedge clk100 or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next  = r_state;
        w_pstate_next = r_pstate;
        w_p0_next     = r_p0;
        w_p1_next     = r_p1;
        w_idx_next    = r_idx;
        w_pend_next   = r_scroll_pend;
        w_issue       = 1'b0;
        w_op_begin    = '0;
        w_op_end      = '0;
        w_op_data     = '0;
        w_op_offset   = '0;
        w_row_i       = int'(r_row);
        w_col_i       = int'(r_col);
        w_cur_i       = w_row_i*COLS + w_col_i;
        w_n_i         = (r_p0 == 8'd0) ? 1 : int'(r_p0);
        w_acc_i       = 0;
        case (r_state)
            S_IDLE: if (w_pop) begin
                case (r_pstate)
                    P_DEF: begin
                        case (w_byte)
                            8'h00, 8'h07: begin end
                            8'h08: if (w_col_i > 0) w_col_i = w_col_i - 1;
                            8'h09: begin
                                w_col_i = (w_col_i / TAB_W + 1) * TAB_W;
                                if (w_col_i > COLS-1) w_col_i = COLS-1;
                            end
                            8'h0A: begin
                                if (w_row_i == ROWS-1) begin
                                    w_issue      = 1'b1;
                                    w_op_end     = ADDR_W'(LAST_BASE);
                                    w_op_offset  = ADDR_W'(COLS);
                                    w_state_next = S_COPY;
                                end else begin
                                    w_row_i = w_row_i + 1;
                                end
                            end
                            8'h0D: w_col_i = 0;
                            8'h1B: w_pstate_next = P_ESC;
                            default: begin
                                w_issue      = 1'b1;
                                w_op_begin   = ADDR_W'(w_cur_i);
                                w_op_end     = ADDR_W'(w_cur_i + 1);
                                w_op_data    = w_byte;
                                w_state_next = S_WAIT;
                                // Wrapping off the last row defers the scroll until this fill completes.
                                if (w_col_i == COLS-1) begin
                                    w_col_i = 0;
                                    if (w_row_i == ROWS-1) w_pend_next = 1'b1;
                                    else                   w_row_i = w_row_i + 1;
                                end else begin
                                    w_col_i = w_col_i + 1;
                                end
                            end
                        endcase
                    end
                    P_ESC: begin
                        if (w_byte == 8'h5B) begin
                            w_pstate_next = P_CSI;
                            w_p0_next     = 8'd0;
                            w_p1_next     = 8'd0;
                            w_idx_next    = 1'b0;
                        end else begin
                            w_pstate_next = P_DEF;
                        end
                    end
                    P_CSI: begin
                        if (w_byte == 8'h1B) begin
                            w_pstate_next = P_ESC;
                        end else if (w_byte >= 8'h30 && w_byte <= 8'h39) begin
                            w_acc_i = (r_idx ? int'(r_p1) : int'(r_p0))*10 + int'(w_byte) - 48;
                            if (w_acc_i > 255) w_acc_i = 255;
                            if (r_idx) w_p1_next = 8'(w_acc_i);
                            else       w_p0_next = 8'(w_acc_i);
                        end else if (w_byte == 8'h3B) begin
                            w_idx_next = 1'b1;
                        end else if (w_byte >= 8'h40 && w_byte <= 8'h7E) begin
                            w_pstate_next = P_DEF;
                            case (w_byte)
                                8'h41: w_row_i = (w_row_i > w_n_i) ? w_row_i - w_n_i : 0;
                                8'h42: w_row_i = (w_row_i + w_n_i > ROWS-1) ? ROWS-1 : w_row_i + w_n_i;
                                8'h43: w_col_i = (w_col_i + w_n_i > COLS-1) ? COLS-1 : w_col_i + w_n_i;
                                8'h44: w_col_i = (w_col_i > w_n_i) ? w_col_i - w_n_i : 0;
                                8'h48, 8'h66: begin
                                    w_row_i = (w_n_i - 1 > ROWS-1) ? ROWS-1 : w_n_i - 1;
                                    w_col_i = ((r_p1 == 8'd0) ? 0 : int'(r_p1) - 1);
                                    if (w_col_i > COLS-1) w_col_i = COLS-1;
                                end
                                8'h4B: if (r_p0 <= 8'd2) begin
                                    w_issue      = 1'b1;
                                    w_state_next = S_WAIT;
                                    w_op_begin   = ADDR_W'((r_p0 == 8'd0) ? w_cur_i : w_row_i*COLS);
                                    w_op_end     = ADDR_W'((r_p0 == 8'd1) ? w_cur_i + 1 : w_row_i*COLS + COLS);
                                end
                                8'h4A: if (r_p0 <= 8'd2) begin
                                    w_issue      = 1'b1;
                                    w_state_next = S_WAIT;
                                    w_op_begin   = ADDR_W'((r_p0 == 8'd0) ? w_cur_i : 0);
                                    w_op_end     = ADDR_W'((r_p0 == 8'd1) ? w_cur_i + 1 : CELLS);
                                end
                                default: begin end
                            endcase
                        end
                    end
                    default: w_pstate_next = P_DEF;
                endcase
            end
            S_WAIT: if (bus.wr_complete) begin
                if (r_scroll_pend) begin
                    w_issue      = 1'b1;
                    w_op_end     = ADDR_W'(LAST_BASE);
                    w_op_offset  = ADDR_W'(COLS);
                    w_pend_next  = 1'b0;
                    w_state_next = S_COPY;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_COPY: if (bus.wr_complete) begin
                w_issue      = 1'b1;
                w_op_begin   = ADDR_W'(LAST_BASE);
                w_op_end     = ADDR_W'(CELLS);
                w_state_next = S_WAIT;
            end
            default: w_state_next = S_IDLE;
        endcase
        w_row_next = ROW_W'(w_row_i);
        w_col_next = COL_W'(w_col_i);
    end

    always_comb begin
        w_pop  = (r_state == S_IDLE) && !w_empty;
        w_busy = (r_state != S_IDLE) || !w_empty;
    end

    always_ff @(posedge clk100 or negedge rst_n) begin
        if (!rst_n) begin
            r_pstate      <= P_DEF;
            r_row         <= '0;
            r_col         <= '0;
            r_p0          <= '0;
            r_p1          <= '0;
            r_idx         <= 1'b0;
            r_scroll_pend <= 1'b0;
            r_cursor      <= '0;
            r_wr_start    <= 1'b0;
            r_wr_begin    <= '0;
            r_wr_end      <= '0;
            r_wr_data     <= '0;
            r_wr_offset   <= '0;
            r_overflow    <= 1'b0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
        end else begin
            r_pstate      <= w_pstate_next;
            r_row         <= w_row_next;
            r_col         <= w_col_next;
            r_p0          <= w_p0_next;
            r_p1          <= w_p1_next;
            r_idx         <= w_idx_next;
            r_scroll_pend <= w_pend_next;
            r_cursor      <= ADDR_W'(int'(r_row)*COLS + int'(r_col));
            r_wr_start    <= w_issue;
            if (w_issue) begin
                r_wr_begin  <= w_op_begin;
                r_wr_end    <= w_op_end;
                r_wr_data   <= w_op_data;
                r_wr_offset <= w_op_offset;
            end
            if (bus.rx_valid && w_full && !w_pop) r_overflow <= 1'b1;
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    assign bus.overflow  = r_overflow;
    assign bus.cursor    = r_cursor;
    assign bus.wr_start  = r_wr_start;
    assign bus.wr_begin  = r_wr_begin;
    assign bus.wr_end    = r_wr_end;
    assign bus.wr_data   = r_wr_data;
    assign bus.wr_offset = r_wr_offset;
    assign bus.busy      = w_busy;
endmodule

// File: tb/tb_term_ctrl.sv
// Bench for term_ctrl: directed scenarios plus random byte bursts, checked
// against a screen-level model of cursor movement and expected buffer ops.
module tb_term_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    term_ctrl_if #(.ADDR_W(11)) bus ();
    term_ctrl #(.COLS(80), .ROWS(25), .FIFO_DEPTH(16), .TAB_W(8)) dut (
        .clk100(clk), .rst_n(rst_n), .bus(bus.master)
    );

    int total = 0;
    int bad = 0;
    int m_row, m_col, m_ps, m_p0, m_p1, m_idx;
    logic [40:0] exp_q[$];
    logic [40:0] obs_q[$];
    bit auto_cpl = 1'b1;
    int late_req = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [40:0] mk_op(int b, int e, int d, int o);
        return {11'(b), 11'(e), 8'(d), 11'(o)};
    endfunction

    // The fill byte is meaningless for copies, so it is masked out before comparing.
    function automatic logic [40:0] norm(logic [40:0] op);
        logic [40:0] r;
        r = op;
        if (r[10:0] != 11'd0) r[18:11] = 8'd0;
        return r;
    endfunction

    function automatic int imin(int a, int b); return (a < b) ? a : b; endfunction
    function automatic int imax(int a, int b); return (a > b) ? a : b; endfunction

    function automatic void model_reset();
        m_row = 0; m_col = 0; m_ps = 0; m_p0 = 0; m_p1 = 0; m_idx = 0;
    endfunction

    function automatic void model_newline();
        if (m_row == 24) begin
            exp_q.push_back(mk_op(0, 1920, 0, 80));
            exp_q.push_back(mk_op(1920, 2000, 0, 0));
        end else m_row++;
    endfunction

    function automatic void model_byte(logic [7:0] b);
        int n, cur;
        cur = m_row*80 + m_col;
        n = (m_p0 == 0) ? 1 : m_p0;
        if (m_ps == 0) begin
            if (b == 8'h00 || b == 8'h07) begin end
            else if (b == 8'h08) m_col = imax(m_col - 1, 0);
            else if (b == 8'h09) m_col = imin((m_col/8 + 1)*8, 79);
            else if (b == 8'h0A) model_newline();
            else if (b == 8'h0D) m_col = 0;
            else if (b == 8'h1B) m_ps = 1;
            else begin
                exp_q.push_back(mk_op(cur, cur + 1, b, 0));
                if (m_col == 79) begin m_col = 0; model_newline(); end
                else m_col++;
            end
        end else if (m_ps == 1) begin
            if (b == "[") begin m_ps = 2; m_p0 = 0; m_p1 = 0; m_idx = 0; end
            else m_ps = 0;
        end else begin
            if (b == 8'h1B) m_ps = 1;
            else if (b >= "0" && b <= "9") begin
                if (m_idx == 0) m_p0 = imin(m_p0*10 + (b - 48), 255);
                else            m_p1 = imin(m_p1*10 + (b - 48), 255);
            end else if (b == ";") m_idx = 1;
            else if (b >= 8'h40 && b <= 8'h7E) begin
                m_ps = 0;
                case (b)
                    "A": m_row = imax(m_row - n, 0);
                    "B": m_row = imin(m_row + n, 24);
                    "C": m_col = imin(m_col + n, 79);
                    "D": m_col = imax(m_col - n, 0);
                    "H", "f": begin
                        m_row = imin(n - 1, 24);
                        m_col = imin(imax(m_p1, 1) - 1, 79);
                    end
                    "K": if (m_p0 == 0) exp_q.push_back(mk_op(cur, m_row*80 + 80, 0, 0));
                         else if (m_p0 == 1) exp_q.push_back(mk_op(m_row*80, cur + 1, 0, 0));
                         else if (m_p0 == 2) exp_q.push_back(mk_op(m_row*80, m_row*80 + 80, 0, 0));
                    "J": if (m_p0 == 0) exp_q.push_back(mk_op(cur, 2000, 0, 0));
                         else if (m_p0 == 1) exp_q.push_back(mk_op(0, cur + 1, 0, 0));
                         else if (m_p0 == 2) exp_q.push_back(mk_op(0, 2000, 0, 0));
                    default: begin end
                endcase
            end
        end
    endfunction

    // Text-buffer responder: logs each request, checks it stays stable, completes it later.
    initial begin
        bit pending;
        int cnt;
        int late_done;
        logic [40:0] held;
        pending = 0; cnt = 0; late_done = 0; held = '0;
        bus.wr_complete = 1'b0;
        forever begin
            @(negedge clk);
            bus.wr_complete = 1'b0;
            if (late_req != late_done) begin
                bus.wr_complete = 1'b1;
                late_done++;
            end else if (!rst_n) begin
                pending = 0;
            end else if (bus.wr_start) begin
                held = {bus.wr_begin, bus.wr_end, bus.wr_data, bus.wr_offset};
                obs_q.push_back(held);
                $display("op begin=%0d end=%0d data=%02h offset=%0d",
                         bus.wr_begin, bus.wr_end, bus.wr_data, bus.wr_offset);
                pending = 1;
                cnt = $urandom_range(0, 3);
            end else if (pending) begin
                check("op_stable", {bus.wr_begin, bus.wr_end, bus.wr_data, bus.wr_offset}, held);
                if (auto_cpl) begin
                    if (cnt == 0) begin bus.wr_complete = 1'b1; pending = 0; end
                    else cnt--;
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.rx_data = b;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_m(input logic [7:0] b);
        model_byte(b);
        send_byte(b);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (bus.busy && n < 3000) begin @(negedge clk); n++; end
        check({tag, "_idle"}, bus.busy, 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_m(s[i]);
        wait_idle(s);
    endtask

    task automatic compare_ops(input string tag);
        check({tag, "_nops"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < imin(obs_q.size(), exp_q.size()); i++)
            check($sformatf("%s_op%0d", tag, i), norm(obs_q[i]), norm(exp_q[i]));
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic check_cursor(input string tag);
        check({tag, "_cursor"}, bus.cursor, m_row*80 + m_col);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        obs_q.delete();
        exp_q.delete();
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] b;
        logic [7:0] finals [8];
        finals = '{"A", "B", "C", "D", "H", "f", "K", "J"};
        bus.rx_data = 8'h00;
        bus.rx_valid = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_cursor", bus.cursor, 0);
        check("rst_wr_start", bus.wr_start, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_overflow", bus.overflow, 0);
        check("rst_wr_end", bus.wr_end, 0);

        send_str("AB");
        compare_ops("ab");
        check("ab_cursor_const", bus.cursor, 2);

        do_reset();
        for (int i = 0; i < 80; i++) begin
            send_m(8'h61 + 8'(i % 26));
            if (i % 8 == 7) wait_idle("row0");
        end
        check("row0_cursor_const", bus.cursor, 80);
        compare_ops("row0");
        send_str("q");
        compare_ops("cell80");

        send_m(8'h1B);
        send_str("[25;1H");
        check_cursor("row24");
        send_m(8'h0A);
        wait_idle("scroll");
        compare_ops("scroll");
        check("scroll_cursor_const", bus.cursor, 1920);

        send_m(8'h1B);
        send_str("[12;40HX");
        compare_ops("pos_x");
        send_m(8'h1B);
        send_str("[999;999H");
        check("clamp_cursor_const", bus.cursor, 1999);

        send_m(8'h1B);
        send_str("[3;6H");
        check("c165", bus.cursor, 165);
        send_m(8'h1B);
        send_str("[1K");
        send_m(8'h1B);
        send_str("[2J");
        compare_ops("erase");
        check_cursor("erase");

        // Wrap on the last row: fill, then copy, then clear bottom line.
        send_m(8'h1B);
        send_str("[25;80Hz");
        compare_ops("wrap_scroll");
        check_cursor("wrap_scroll");

        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                send_m(8'h1B);
                send_m("[");
                for (int j = 0; j < $urandom_range(0, 4); j++) begin
                    b = ($urandom_range(0, 4) == 0) ? ";" : 8'(8'h30 + $urandom_range(0, 9));
                    send_m(b);
                end
                send_m(finals[$urandom_range(0, 7)]);
            end else begin
                for (int j = 0; j < $urandom_range(1, 10); j++) begin
                    case ($urandom_range(0, 9))
                        0, 1, 2, 3, 4, 5: b = 8'($urandom_range(8'h20, 8'h7E));
                        6: b = 8'($urandom_range(0, 13));
                        7: b = 8'($urandom_range(8'h80, 8'hFF));
                        8: b = 8'h0A;
                        default: b = 8'h1B;
                    endcase
                    send_m(b);
                end
            end
            wait_idle("rand");
            compare_ops($sformatf("rand%0d", k));
            check_cursor($sformatf("rand%0d", k));
        end

        do_reset();
        auto_cpl = 1'b0;
        send_m("Z");
        repeat (3) @(negedge clk);
        for (int i = 0; i < 17; i++) begin
            if (i < 16) model_byte(8'h61 + 8'(i));
            send_byte(8'h61 + 8'(i));
        end
        check("ovf_set", bus.overflow, 1);
        auto_cpl = 1'b1;
        wait_idle("ovf");
        compare_ops("ovf");
        check_cursor("ovf");
        check("ovf_sticky", bus.overflow, 1);

        do_reset();
        auto_cpl = 1'b0;
        send_byte("M");
        repeat (3) @(negedge clk);
        send_byte("N");
        rst_n = 1'b0;
        #1;
        check("midrst_start", bus.wr_start, 0);
        check("midrst_end", bus.wr_end, 0);
        check("midrst_busy", bus.busy, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        late_req++;
        repeat (3) @(negedge clk);
        model_reset();
        obs_q.delete();
        exp_q.delete();
        auto_cpl = 1'b1;
        check("midrst_ovf", bus.overflow, 0);
        send_str("Q");
        compare_ops("after_rst");
        check_cursor("after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5ms;
        check("global_timeout", 1, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end
endmodule
